// File: rtl/gpio_bidir_ctrl.sv
// gpio_bidir_ctrl: write sequencer and readback debouncer for one bidirectional GPIO bank.
// Drive bursts are wrapped in dead turnaround cycles with the pins released. Readback is
// debounced only while the bank is in its input phase.
module gpio_bidir_ctrl #(
  parameter int WIDTH    = 1,
  parameter int TURN_CYC = 2,
  parameter int DEB_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [7:0]       wr_hold_i,
  output logic             wr_ready_o,
  output logic [WIDTH-1:0] gpio_din_o,
  output logic             gpio_tristate_o,
  input  logic [WIDTH-1:0] gpio_dout_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             busy_o
);

  // The turn counter needs at least one bit even when turnaround is disabled.
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC);

  typedef enum logic [1:0] {IDLE_IN, TURN_OUT, DRIVE, TURN_IN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rst_pipe;
  logic             rst_int_n;
  logic             accept;
  logic [7:0]       hold_cnt;
  logic [TW-1:0]    turn_cnt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] cand;
  logic [DW-1:0]    cnt;

  // Reset synchronizer: assertion is immediate, release is aligned to two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  // Pins are released whenever the FSM is outside DRIVE, so reset releases them asynchronously.
  assign wr_ready_o      = (state == IDLE_IN);
  assign busy_o          = (state != IDLE_IN);
  assign gpio_tristate_o = (state != DRIVE);
  assign gpio_din_o      = data_q;
  assign accept          = wr_valid_i & wr_ready_o;

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE_IN;
    else            state <= state_nxt;
  end

  // Next-state logic for the turnaround/drive sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_IN:  if (accept) state_nxt = (TURN_CYC == 0) ? DRIVE : TURN_OUT;
      TURN_OUT: if (turn_cnt == TURN_LAST) state_nxt = DRIVE;
      DRIVE:    if (hold_cnt <= 8'd1) state_nxt = (TURN_CYC == 0) ? IDLE_IN : TURN_IN;
      TURN_IN:  if (turn_cnt == TURN_LAST) state_nxt = IDLE_IN;
      default:  state_nxt = IDLE_IN;
    endcase
  end

  // Write capture plus hold/turn counters; the turn counter wraps to zero ready for the next turn phase.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hold_cnt <= 8'd0;
      turn_cnt <= '0;
      data_q   <= '0;
    end else if (accept) begin
      hold_cnt <= (wr_hold_i == 8'd0) ? 8'd1 : wr_hold_i;
      turn_cnt <= '0;
      data_q   <= wr_data_i;
    end else begin
      case (state)
        TURN_OUT, TURN_IN: turn_cnt <= (turn_cnt == TURN_LAST) ? '0 : turn_cnt + 1'b1;
        DRIVE:             hold_cnt <= hold_cnt - 8'd1;
        default:           ;
      endcase
    end
  end

  // Readback debounce: commit after DEB_CYC matching samples; edges only within a valid phase.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s_q        <= '0;
      cand       <= '0;
      cnt        <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rise_o     <= '0;
      fall_o     <= '0;
    end else begin
      s_q    <= gpio_dout_i;
      rise_o <= '0;
      fall_o <= '0;
      if (accept) begin
        rd_valid_o <= 1'b0;
        cand       <= '0;
        cnt        <= '0;
      end else if (state == IDLE_IN) begin
        if (s_q != cand) begin
          cand <= s_q;
          cnt  <= '0;
        end else begin
          if (cnt != DEB_MAX) cnt <= cnt + 1'b1;
          if (cnt == DEB_LAST) begin
            rd_data_o  <= cand;
            rd_valid_o <= 1'b1;
            if (rd_valid_o) begin
              rise_o <= cand & ~rd_data_o;
              fall_o <= ~cand & rd_data_o;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_bidir_ctrl.sv
// Testbench for gpio_bidir_ctrl: transaction-level reference model with per-cycle compare,
// directed literal checks and randomized pin/write traffic.
module tb_gpio_bidir_ctrl;

  localparam int W = 4;
  localparam int T = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic [7:0]   wr_hold;
  logic         ready;
  logic [W-1:0] din;
  logic         tri_s;
  logic [W-1:0] pin;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         busy;

  // Second instance with no turnaround cycles.
  logic         w2_valid;
  logic [W-1:0] w2_data;
  logic [7:0]   w2_hold;
  logic         ready2;
  logic [W-1:0] din2;
  logic         tri2;
  logic [W-1:0] pin2;
  logic [W-1:0] rd_data2;
  logic         rd_valid2;
  logic [W-1:0] rise2;
  logic [W-1:0] fall2;
  logic         busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bidir_ctrl #(.WIDTH(W), .TURN_CYC(T), .DEB_CYC(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_hold_i(wr_hold),
    .wr_ready_o(ready), .gpio_din_o(din), .gpio_tristate_o(tri_s), .gpio_dout_i(pin),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rise_o(rise), .fall_o(fall), .busy_o(busy)
  );

  gpio_bidir_ctrl #(.WIDTH(W), .TURN_CYC(0), .DEB_CYC(D)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(w2_valid), .wr_data_i(w2_data), .wr_hold_i(w2_hold),
    .wr_ready_o(ready2), .gpio_din_o(din2), .gpio_tristate_o(tri2), .gpio_dout_i(pin2),
    .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .rise_o(rise2), .fall_o(fall2), .busy_o(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Write side: time since accept decides the phase. Read side: history of sampled levels in
  // the current input phase (a phantom 0 opens each phase); a level commits when it has filled
  // exactly the last D+1 slots of that history.
  int           sync_cnt;
  bit           m_idle;
  int           m_t;
  int           m_h;
  logic [W-1:0] m_data;
  logic [W-1:0] m_sq;
  logic [W-1:0] m_rd;
  bit           m_vld;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] hist[$];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] prev;
    int           n;
    bit           run;
    if (!rst_n) begin
      sync_cnt = 0;
      m_idle = 1; m_t = 0; m_h = 1; m_data = '0;
      m_sq = '0; m_rd = '0; m_vld = 0; m_rise = '0; m_fall = '0;
      hist.delete(); hist.push_back('0);
    end else if (sync_cnt < 2) begin
      sync_cnt++;
    end else begin
      prev = m_sq;
      m_sq = pin;
      m_rise = '0;
      m_fall = '0;
      if (m_idle) begin
        if (wr_valid) begin
          m_idle = 0; m_t = 0;
          m_h = (wr_hold == 8'd0) ? 1 : int'(wr_hold);
          m_data = wr_data;
          m_vld = 0;
          hist.delete(); hist.push_back('0);
        end else begin
          hist.push_back(prev);
          while (hist.size() > D + 2) void'(hist.pop_front());
          n = hist.size();
          run = (n >= D + 1);
          for (int k = 0; k <= D; k++)
            if (run && hist[n-1-k] != hist[n-1]) run = 0;
          if (run && n > D + 1 && hist[n-D-2] == hist[n-1]) run = 0;
          if (run) begin
            if (m_vld) begin
              m_rise = hist[n-1] & ~m_rd;
              m_fall = ~hist[n-1] & m_rd;
            end
            m_rd = hist[n-1];
            m_vld = 1;
          end
        end
      end else begin
        m_t++;
        if (m_t >= 2*T + m_h) m_idle = 1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit exp_tri;
    exp_tri = m_idle || (m_t < T) || (m_t >= T + m_h);
    chk("ready", ready, m_idle);
    chk("busy", busy, !m_idle);
    chk("tristate", tri_s, exp_tri);
    if (!exp_tri) chk("din", din, m_data);
    chk("rd_valid", rd_valid, m_vld);
    if (m_vld) chk("rd_data", rd_data, m_rd);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 0; wr_data = '0; wr_hold = 8'd0; pin = '0;
    w2_valid = 0; w2_data = '0; w2_hold = 8'd0; pin2 = '0;
    repeat (3) tick();

    // 1: reset state and first commit at edge 6 after release
    chk("rst_tristate", tri_s, 1);
    chk("rst_din", din, 0);
    chk("rst_ready", ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rdv_edge5", rd_valid, 0);
    tick();
    chk("rdv_edge6", rd_valid, 1);
    chk("rd_edge6", rd_data, 0);
    chk("rise_edge6", rise, 0);

    // 2: stable change 0 -> 5
    pin = 4'h5;
    repeat (5) tick();
    chk("chg_rd_e5", rd_data, 4'h0);
    tick();
    chk("chg_rd_e6", rd_data, 4'h5);
    chk("chg_rise", rise, 4'h5);
    chk("chg_fall", fall, 4'h0);
    tick();
    chk("chg_rise_off", rise, 4'h0);

    // 3: back to 0, then a 3-cycle glitch
    pin = 4'h0;
    repeat (8) tick();
    pin = 4'h1;
    repeat (3) tick();
    pin = 4'h0;
    repeat (10) tick();
    chk("glitch_rd", rd_data, 4'h0);

    // 5b: TURN_CYC=0 instance
    w2_valid = 1; w2_data = 4'h5; w2_hold = 8'd2;
    tick();
    w2_valid = 0;
    chk("t0_tri_i0", tri2, 0);
    chk("t0_din_i0", din2, 4'h5);
    chk("t0_ready_i0", ready2, 0);
    tick();
    chk("t0_tri_i1", tri2, 0);
    tick();
    chk("t0_ready_i2", ready2, 1);
    chk("t0_tri_i2", tri2, 1);
    w2_valid = 1; w2_data = 4'h3; w2_hold = 8'd0;
    tick();
    w2_valid = 0;
    chk("t0h0_tri", tri2, 0);
    tick();
    chk("t0h0_ready", ready2, 1);

    // 4: write 0xA hold 3
    wr_valid = 1; wr_data = 4'hA; wr_hold = 8'd3;
    tick();
    wr_valid = 0;
    chk("wr_rdv", rd_valid, 0);
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) tick();
      chk($sformatf("wr_tri_%0d", i), tri_s, (i < 2 || i >= 5));
      chk($sformatf("wr_ready_%0d", i), ready, (i == 7));
      if (i >= 2 && i < 5) chk($sformatf("wr_din_%0d", i), din, 4'hA);
    end

    // 5a: hold 0 -> one drive cycle
    wr_valid = 1; wr_data = 4'h7; wr_hold = 8'd0;
    tick();
    wr_valid = 0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("h0_tri_%0d", i), tri_s, (i != 2));
      chk($sformatf("h0_ready_%0d", i), ready, (i == 5));
    end

    // 6: reset in the 2nd drive cycle
    wr_valid = 1; wr_data = 4'h6; wr_hold = 8'd5;
    tick();
    wr_valid = 0;
    repeat (3) tick();
    chk("mid_tri_before", tri_s, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_tri_async", tri_s, 1);
    chk("mid_din_async", din, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_busy", busy, 0);
    chk("post_ready", ready, 1);
    chk("post_rdv", rd_valid, 1);

    // back-to-back writes with valid held high
    wr_valid = 1; wr_data = 4'h9; wr_hold = 8'd2;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) chk("b2b_ready6", ready, 1);
      if (i == 7) chk("b2b_ready7", ready, 0);
    end
    wr_valid = 0;
    repeat (8) tick();
    chk("b2b_idle", ready, 1);

    // mixed change 0x3 -> 0xC
    pin = 4'h3;
    repeat (8) tick();
    pin = 4'hC;
    repeat (5) tick();
    chk("mix_rd_e5", rd_data, 4'h3);
    tick();
    chk("mix_rd_e6", rd_data, 4'hC);
    chk("mix_rise", rise, 4'hC);
    chk("mix_fall", fall, 4'h3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) pin = W'($urandom);
      wr_valid = ($urandom_range(0, 9) == 0);
      wr_data  = W'($urandom);
      wr_hold  = 8'($urandom_range(0, 6));
    end
    wr_valid = 0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
